// File: rtl/mem_access_ctrl_if.sv
// Data-bus channel between the MEM-stage access controller and data memory.
// Requests use valid/ready; the response is a single-cycle drsp_valid strobe with no backpressure.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  dreq_valid;
   logic                  dreq_ready;
   logic                  dreq_wr;
   logic [ADDR_W-1:0]     dreq_addr;
   logic [DATA_W/8-1:0]   dreq_wstrb;
   logic [DATA_W-1:0]     dreq_wdata;
   logic                  drsp_valid;
   logic [DATA_W-1:0]     drsp_rdata;

   modport master (
      output dreq_valid, dreq_wr, dreq_addr, dreq_wstrb, dreq_wdata,
      input  dreq_ready, drsp_valid, drsp_rdata
   );

   modport slave (
      input  dreq_valid, dreq_wr, dreq_addr, dreq_wstrb, dreq_wdata,
      output dreq_ready, drsp_valid, drsp_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: one bus transaction per load/store, load data aligned/extended for WB; DMEM_UNALIGNED_EN adds LWL/LWR/SWL/SWR.
// Accept to DONE takes 2 cycles plus bus wait; stalls the pipeline until DONE, a flush drops the stall but the bus transaction still completes.
module mem_access_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_flush,
   input  logic              mem_valid,
   input  logic [2:0]        mem_load_op,
   input  logic [2:0]        mem_store_op,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rt_old,
   input  logic              mem_except,
   output logic              mem_stall,
   output logic              mem_busy,
   output logic              ld_done,
   output logic [DATA_W-1:0] ld_data,
   mem_access_ctrl_if.master dbus
);

   localparam logic [2:0] LD_LB  = 3'd1;
   localparam logic [2:0] LD_LBU = 3'd2;
   localparam logic [2:0] LD_LH  = 3'd3;
   localparam logic [2:0] LD_LHU = 3'd4;
   localparam logic [2:0] LD_LW  = 3'd5;
   localparam logic [2:0] ST_SB  = 3'd1;
   localparam logic [2:0] ST_SH  = 3'd2;
   localparam logic [2:0] ST_SW  = 3'd3;
`ifdef DMEM_UNALIGNED_EN
   localparam logic [2:0] LD_LWL = 3'd6;
   localparam logic [2:0] LD_LWR = 3'd7;
   localparam logic [2:0] ST_SWL = 3'd4;
   localparam logic [2:0] ST_SWR = 3'd5;
`endif

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                kill_q, kill_d;
   logic                is_load_q, is_load_d;
   logic [2:0]          load_op_q, load_op_d;
   logic [1:0]          k_q, k_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   ld_data_q, ld_data_d;
`ifdef DMEM_UNALIGNED_EN
   logic [DATA_W-1:0]   rt_old_q, rt_old_d;
`endif

   logic                ld_any, st_any, no_bus, accept;
   logic [1:0]          k_in;
   logic [3:0]          wstrb_new;
   logic [DATA_W-1:0]   wdata_new;
   logic [7:0]          rbyte;
   logic [15:0]         rhalf;
   logic [DATA_W-1:0]   ld_ext;

   assign k_in = mem_addr[1:0];

   // Decode the incoming op; no_bus marks ops completed locally without a bus request.
   always_comb begin
      ld_any = (mem_load_op != 3'd0);
      st_any = (mem_store_op >= 3'd1) && (mem_store_op <= 3'd5);
`ifdef DMEM_UNALIGNED_EN
      no_bus = 1'b0;
`else
      no_bus = ld_any ? (mem_load_op >= 3'd6) : (mem_store_op >= 3'd4);
`endif
      accept = (state_q == S_IDLE) && mem_valid && !mem_except && !mem_flush
               && (ld_any || st_any);
   end

   always_comb begin
      wstrb_new = 4'b0000;
      wdata_new = '0;
      case (mem_store_op)
         ST_SB: begin
            wstrb_new = 4'b0001 << k_in;
            wdata_new = {4{mem_wdata[7:0]}};
         end
         ST_SH: begin
            wstrb_new = k_in[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{mem_wdata[15:0]}};
         end
         ST_SW: begin
            wstrb_new = 4'b1111;
            wdata_new = mem_wdata;
         end
`ifdef DMEM_UNALIGNED_EN
         ST_SWL: begin
            wstrb_new = 4'b1111 >> ~k_in;
            wdata_new = mem_wdata >> {~k_in, 3'b000};
         end
         ST_SWR: begin
            wstrb_new = 4'b1111 << k_in;
            wdata_new = mem_wdata << {k_in, 3'b000};
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      case (k_q)
         2'd0:    rbyte = dbus.drsp_rdata[7:0];
         2'd1:    rbyte = dbus.drsp_rdata[15:8];
         2'd2:    rbyte = dbus.drsp_rdata[23:16];
         default: rbyte = dbus.drsp_rdata[31:24];
      endcase
      rhalf  = k_q[1] ? dbus.drsp_rdata[31:16] : dbus.drsp_rdata[15:0];
      ld_ext = dbus.drsp_rdata;
      case (load_op_q)
         LD_LB:  ld_ext = {{24{rbyte[7]}}, rbyte};
         LD_LBU: ld_ext = {24'd0, rbyte};
         LD_LH:  ld_ext = {{16{rhalf[15]}}, rhalf};
         LD_LHU: ld_ext = {16'd0, rhalf};
         LD_LW:  ld_ext = dbus.drsp_rdata;
`ifdef DMEM_UNALIGNED_EN
         LD_LWL: ld_ext = (dbus.drsp_rdata << {~k_q, 3'b000})
                        | (rt_old_q & (32'h00FF_FFFF >> {k_q, 3'b000}));
         LD_LWR: ld_ext = (dbus.drsp_rdata >> {k_q, 3'b000})
                        | (rt_old_q & ~(32'hFFFF_FFFF >> {k_q, 3'b000}));
`endif
         default: ;
      endcase
   end

   // Next-state logic; a response seen in REQ is ignored since the bus cannot answer before acceptance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = no_bus ? S_DONE : S_REQ;
         S_REQ:  if (dbus.dreq_ready) state_d = S_WAIT;
         S_WAIT: if (dbus.drsp_valid) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      kill_d    = kill_q;
      is_load_d = is_load_q;
      load_op_d = load_op_q;
      k_d       = k_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wstrb_d   = wstrb_q;
      wdata_d   = wdata_q;
      ld_data_d = ld_data_q;
`ifdef DMEM_UNALIGNED_EN
      rt_old_d  = rt_old_q;
`endif
      if (accept) begin
         is_load_d = ld_any;
         load_op_d = mem_load_op;
         k_d       = k_in;
         wr_d      = !ld_any;
         addr_d    = {mem_addr[ADDR_W-1:2], 2'b00};
         wstrb_d   = ld_any ? 4'b0000 : wstrb_new;
         wdata_d   = ld_any ? '0 : wdata_new;
`ifdef DMEM_UNALIGNED_EN
         rt_old_d  = mem_rt_old;
`else
         if (no_bus && ld_any) ld_data_d = mem_rt_old;
`endif
      end
      if ((state_q == S_REQ || state_q == S_WAIT) && mem_flush) kill_d = 1'b1;
      if (state_q == S_DONE) kill_d = 1'b0;
      if (state_q == S_WAIT && dbus.drsp_valid && is_load_q && !kill_d) ld_data_d = ld_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         kill_q    <= 1'b0;
         is_load_q <= 1'b0;
         load_op_q <= 3'd0;
         k_q       <= 2'd0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wstrb_q   <= 4'b0000;
         wdata_q   <= '0;
         ld_data_q <= '0;
`ifdef DMEM_UNALIGNED_EN
         rt_old_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         kill_q    <= kill_d;
         is_load_q <= is_load_d;
         load_op_q <= load_op_d;
         k_q       <= k_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wstrb_q   <= wstrb_d;
         wdata_q   <= wdata_d;
         ld_data_q <= ld_data_d;
`ifdef DMEM_UNALIGNED_EN
         rt_old_q  <= rt_old_d;
`endif
      end
   end

   // Stall drops in the flush cycle itself, before kill_q has registered.
   always_comb begin
      dbus.dreq_valid = (state_q == S_REQ);
      mem_busy        = (state_q != S_IDLE);
      ld_done         = (state_q == S_DONE) && is_load_q && !kill_q;
      mem_stall       = accept
                        || ((state_q == S_REQ || state_q == S_WAIT) && !kill_q && !mem_flush);
   end

   assign dbus.dreq_wr    = wr_q;
   assign dbus.dreq_addr  = addr_q;
   assign dbus.dreq_wstrb = wstrb_q;
   assign dbus.dreq_wdata = wdata_q;
   assign ld_data         = ld_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the bench plays the data-memory side of the bus.
module tb_mem_access_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_flush, mem_valid, mem_except;
   logic [2:0]  mem_load_op, mem_store_op;
   logic [31:0] mem_addr, mem_wdata, mem_rt_old;
   logic        mem_stall, mem_busy, ld_done;
   logic [31:0] ld_data;

   int checks = 0;
   int errors = 0;
   int ld_done_cnt = 0;
   int hs_cnt = 0;
   int vld_cnt = 0;

   mem_access_ctrl_if bus_if ();

   mem_access_ctrl dut (
      .clk(clk), .rst(rst), .mem_flush(mem_flush), .mem_valid(mem_valid),
      .mem_load_op(mem_load_op), .mem_store_op(mem_store_op), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rt_old(mem_rt_old), .mem_except(mem_except),
      .mem_stall(mem_stall), .mem_busy(mem_busy), .ld_done(ld_done), .ld_data(ld_data),
      .dbus(bus_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ld_done === 1'b1) ld_done_cnt++;
      if (bus_if.dreq_valid === 1'b1 && bus_if.dreq_ready === 1'b1) hs_cnt++;
      if (bus_if.dreq_valid === 1'b1) vld_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      mem_valid = 1'b0; mem_flush = 1'b0; mem_except = 1'b0;
      mem_load_op = 3'd0; mem_store_op = 3'd0;
   endtask

   task automatic issue(input logic [2:0] lop, input logic [2:0] sop,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rt);
      mem_valid = 1'b1; mem_load_op = lop; mem_store_op = sop;
      mem_addr = addr; mem_wdata = wd; mem_rt_old = rt;
   endtask

   task automatic do_load(input logic [2:0] lop, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] rt, output logic done, output logic [31:0] data);
      issue(lop, 3'd0, addr, 32'd0, rt);
      tick; idle_inputs; bus_if.dreq_ready = 1'b1;
      tick; bus_if.dreq_ready = 1'b0; bus_if.drsp_valid = 1'b1; bus_if.drsp_rdata = rdata;
      tick; bus_if.drsp_valid = 1'b0;
      done = ld_done; data = ld_data;
      tick;
   endtask

   task automatic do_store(input logic [2:0] sop, input logic [31:0] addr, input logic [31:0] wd,
                           output logic wr, output logic [3:0] strb, output logic [31:0] wdata,
                           output logic [31:0] a);
      issue(3'd0, sop, addr, wd, 32'd0);
      tick; idle_inputs;
      wr = bus_if.dreq_wr; strb = bus_if.dreq_wstrb; wdata = bus_if.dreq_wdata; a = bus_if.dreq_addr;
      bus_if.dreq_ready = 1'b1;
      tick; bus_if.dreq_ready = 1'b0; bus_if.drsp_valid = 1'b1;
      tick; bus_if.drsp_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      rst = 1'b1; idle_inputs; mem_addr = '0; mem_wdata = '0; mem_rt_old = '0;
      bus_if.dreq_ready = 1'b0; bus_if.drsp_valid = 1'b0; bus_if.drsp_rdata = '0;
      repeat (3) tick;
      checks++; if ({bus_if.dreq_valid, bus_if.dreq_wr, ld_done, mem_stall, mem_busy} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b required 00000",
                            {bus_if.dreq_valid, bus_if.dreq_wr, ld_done, mem_stall, mem_busy}); end
      checks++; if (bus_if.dreq_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", bus_if.dreq_addr); end
      checks++; if (bus_if.dreq_wstrb !== 4'd0) begin errors++; $display("FAIL reset_wstrb: got %b required 0000", bus_if.dreq_wstrb); end
      checks++; if (bus_if.dreq_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h required 0", bus_if.dreq_wdata); end
      checks++; if (ld_data !== 32'd0) begin errors++; $display("FAIL reset_ld_data: got %h required 0", ld_data); end
      rst = 1'b0;
      tick;
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", mem_busy); end
   endtask

   task automatic test_lb;
      int base = ld_done_cnt;
      issue(3'd1, 3'd0, 32'h0000_1003, 32'd0, 32'd0);
      bus_if.dreq_ready = 1'b1;
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lb_stall_accept: got %b required 1", mem_stall); end
      tick; idle_inputs;
      checks++; if ({bus_if.dreq_valid, bus_if.dreq_wr, mem_stall} !== 3'b101) begin
         errors++; $display("FAIL lb_req_ctrl: got %b required 101", {bus_if.dreq_valid, bus_if.dreq_wr, mem_stall}); end
      checks++; if (bus_if.dreq_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h required 00001000", bus_if.dreq_addr); end
      tick; bus_if.dreq_ready = 1'b0;
      checks++; if ({bus_if.dreq_valid, mem_stall, ld_done} !== 3'b010) begin
         errors++; $display("FAIL lb_wait1: got %b required 010", {bus_if.dreq_valid, mem_stall, ld_done}); end
      tick; bus_if.drsp_valid = 1'b1; bus_if.drsp_rdata = 32'h80FF_0000;
      #1;
      checks++; if ({mem_stall, ld_done} !== 2'b10) begin errors++; $display("FAIL lb_wait2: got %b required 10", {mem_stall, ld_done}); end
      tick; bus_if.drsp_valid = 1'b0;
      checks++; if ({ld_done, mem_stall, mem_busy} !== 3'b101) begin
         errors++; $display("FAIL lb_done_ctrl: got %b required 101", {ld_done, mem_stall, mem_busy}); end
      checks++; if (ld_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h required ffffff80", ld_data); end
      tick;
      checks++; if ({ld_done, mem_busy} !== 2'b00) begin errors++; $display("FAIL lb_back_idle: got %b required 00", {ld_done, mem_busy}); end
      checks++; if (ld_done_cnt - base != 1) begin errors++; $display("FAIL lb_pulse_count: got %0d required 1", ld_done_cnt - base); end
   endtask

   task automatic test_sh;
      int base = ld_done_cnt;
      issue(3'd0, 3'd2, 32'h0000_2002, 32'h0000_BEEF, 32'd0);
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL sh_stall_accept: got %b required 1", mem_stall); end
      tick; idle_inputs;
      checks++; if ({bus_if.dreq_valid, bus_if.dreq_wr, bus_if.dreq_wstrb} !== 6'b11_1100) begin
         errors++; $display("FAIL sh_ctrl: got %b required 111100", {bus_if.dreq_valid, bus_if.dreq_wr, bus_if.dreq_wstrb}); end
      checks++; if (bus_if.dreq_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h required beefbeef", bus_if.dreq_wdata); end
      checks++; if (bus_if.dreq_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h required 00002000", bus_if.dreq_addr); end
      bus_if.dreq_ready = 1'b1;
      tick; bus_if.dreq_ready = 1'b0; bus_if.drsp_valid = 1'b1;
      tick; bus_if.drsp_valid = 1'b0;
      checks++; if ({ld_done, mem_stall, mem_busy} !== 3'b001) begin
         errors++; $display("FAIL sh_done: got %b required 001", {ld_done, mem_stall, mem_busy}); end
      tick;
      checks++; if (ld_done_cnt != base) begin errors++; $display("FAIL sh_no_ld_done: got %0d pulses required 0", ld_done_cnt - base); end
   endtask

   logic [2:0]  lx_op    [7] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd3, 3'd5, 3'd1};
   logic [31:0] lx_addr  [7] = '{32'h1001, 32'h1000, 32'h1002, 32'h1002, 32'h1000, 32'h1004, 32'h1002};
   logic [31:0] lx_rdata [7] = '{32'h1234_8056, 32'h0000_007F, 32'h8001_0000, 32'h8001_1234,
                                 32'hFFFF_7FFE, 32'hDEAD_BEEF, 32'h00AB_0000};
   logic [31:0] lx_exp   [7] = '{32'h0000_0080, 32'h0000_007F, 32'hFFFF_8001, 32'h0000_8001,
                                 32'h0000_7FFE, 32'hDEAD_BEEF, 32'hFFFF_FFAB};

   task automatic test_load_extract;
      logic done;
      logic [31:0] data;
      for (int i = 0; i < 7; i++) begin
         do_load(lx_op[i], lx_addr[i], lx_rdata[i], 32'h5555_5555, done, data);
         checks++; if (done !== 1'b1 || data !== lx_exp[i]) begin
            errors++; $display("FAIL load_extract[%0d]: got done=%b data=%h required done=1 data=%h", i, done, data, lx_exp[i]); end
      end
   endtask

   logic [2:0]  sx_op    [4] = '{3'd1, 3'd1, 3'd2, 3'd3};
   logic [31:0] sx_addr  [4] = '{32'h2001, 32'h2003, 32'h2000, 32'h2008};
   logic [31:0] sx_wd    [4] = '{32'h1234_56A5, 32'h0000_007E, 32'hFFFF_1234, 32'h89AB_CDEF};
   logic [3:0]  sx_strb  [4] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111};
   logic [31:0] sx_exp   [4] = '{32'hA5A5_A5A5, 32'h7E7E_7E7E, 32'h1234_1234, 32'h89AB_CDEF};

   task automatic test_store_lanes;
      logic wr;
      logic [3:0] strb;
      logic [31:0] wdata, a;
      for (int i = 0; i < 4; i++) begin
         do_store(sx_op[i], sx_addr[i], sx_wd[i], wr, strb, wdata, a);
         checks++; if (wr !== 1'b1 || strb !== sx_strb[i] || wdata !== sx_exp[i] || a !== {sx_addr[i][31:2], 2'b00}) begin
            errors++; $display("FAIL store_lanes[%0d]: got wr=%b strb=%b wdata=%h addr=%h required wr=1 strb=%b wdata=%h",
                               i, wr, strb, wdata, a, sx_strb[i], sx_exp[i]); end
      end
   endtask

   task automatic test_back_to_back;
      int base = hs_cnt;
      issue(3'd0, 3'd3, 32'h0000_3004, 32'hCAFE_F00D, 32'd0);
      tick; idle_inputs;
      for (int i = 0; i < 5; i++) begin
         checks++; if ({bus_if.dreq_valid, bus_if.dreq_wr, bus_if.dreq_wstrb, bus_if.dreq_addr, bus_if.dreq_wdata}
                       !== {1'b1, 1'b1, 4'b1111, 32'h0000_3004, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL hold_req[%0d]: got vld=%b wr=%b strb=%b addr=%h wdata=%h required 1 1 1111 00003004 cafef00d",
                               i, bus_if.dreq_valid, bus_if.dreq_wr, bus_if.dreq_wstrb, bus_if.dreq_addr, bus_if.dreq_wdata); end
         tick;
      end
      bus_if.dreq_ready = 1'b1; bus_if.drsp_valid = 1'b1;
      tick; bus_if.dreq_ready = 1'b0; bus_if.drsp_valid = 1'b0;
      #1;
      checks++; if ({bus_if.dreq_valid, mem_stall, mem_busy} !== 3'b011) begin
         errors++; $display("FAIL early_rsp_ignored: got %b required 011", {bus_if.dreq_valid, mem_stall, mem_busy}); end
      bus_if.drsp_valid = 1'b1;
      tick; bus_if.drsp_valid = 1'b0;
      checks++; if ({mem_stall, mem_busy} !== 2'b01) begin errors++; $display("FAIL hold_done: got %b required 01", {mem_stall, mem_busy}); end
      tick;
      checks++; if (hs_cnt - base != 1) begin errors++; $display("FAIL hold_handshakes: got %0d required 1", hs_cnt - base); end
   endtask

   task automatic test_flush;
      logic done;
      logic [31:0] data;
      int base;
      do_load(3'd5, 32'h0000_4000, 32'h0BAD_F00D, 32'd0, done, data);
      base = ld_done_cnt;
      issue(3'd5, 3'd0, 32'h0000_4010, 32'd0, 32'd0);
      tick; idle_inputs; bus_if.dreq_ready = 1'b1;
      tick; bus_if.dreq_ready = 1'b0; mem_flush = 1'b1;
      #1;
      checks++; if ({mem_stall, mem_busy} !== 2'b01) begin errors++; $display("FAIL flush_stall_drop: got %b required 01", {mem_stall, mem_busy}); end
      tick; mem_flush = 1'b0;
      issue(3'd5, 3'd0, 32'h0000_5000, 32'd0, 32'd0);
      #1;
      checks++; if ({mem_stall, mem_busy, bus_if.dreq_valid} !== 3'b010) begin
         errors++; $display("FAIL flush_blocked: got %b required 010", {mem_stall, mem_busy, bus_if.dreq_valid}); end
      tick; bus_if.drsp_valid = 1'b1; bus_if.drsp_rdata = 32'h1111_1111;
      tick; bus_if.drsp_valid = 1'b0;
      checks++; if ({ld_done, mem_stall, mem_busy} !== 3'b001) begin
         errors++; $display("FAIL flush_done_ctrl: got %b required 001", {ld_done, mem_stall, mem_busy}); end
      checks++; if (ld_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL flush_data_kept: got %h required 0badf00d", ld_data); end
      tick;
      checks++; if ({mem_stall, mem_busy} !== 2'b10) begin errors++; $display("FAIL flush_next_accept: got %b required 10", {mem_stall, mem_busy}); end
      tick; idle_inputs;
      checks++; if (bus_if.dreq_valid !== 1'b1 || bus_if.dreq_addr !== 32'h0000_5000) begin
         errors++; $display("FAIL flush_next_req: got vld=%b addr=%h required 1 00005000", bus_if.dreq_valid, bus_if.dreq_addr); end
      bus_if.dreq_ready = 1'b1;
      tick; bus_if.dreq_ready = 1'b0; bus_if.drsp_valid = 1'b1; bus_if.drsp_rdata = 32'h2222_3333;
      tick; bus_if.drsp_valid = 1'b0;
      checks++; if (ld_done !== 1'b1 || ld_data !== 32'h2222_3333) begin
         errors++; $display("FAIL flush_next_load: got done=%b data=%h required 1 22223333", ld_done, ld_data); end
      tick;
      checks++; if (ld_done_cnt - base != 1) begin errors++; $display("FAIL flush_pulse_count: got %0d required 1", ld_done_cnt - base); end
   endtask

   task automatic test_except;
      int vbase = vld_cnt;
      int lbase = ld_done_cnt;
      issue(3'd5, 3'd0, 32'h0000_7000, 32'd0, 32'd0);
      mem_except = 1'b1;
      #1;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL except_stall: got %b required 0", mem_stall); end
      repeat (3) tick;
      checks++; if ({mem_busy, bus_if.dreq_valid, mem_stall} !== 3'b000) begin
         errors++; $display("FAIL except_idle: got %b required 000", {mem_busy, bus_if.dreq_valid, mem_stall}); end
      mem_except = 1'b0; mem_flush = 1'b1;
      #1;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL idle_flush_stall: got %b required 0", mem_stall); end
      tick; idle_inputs;
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL idle_flush_busy: got %b required 0", mem_busy); end
      tick;
      checks++; if (vld_cnt != vbase || ld_done_cnt != lbase) begin
         errors++; $display("FAIL except_no_activity: got %0d valid cycles %0d pulses required 0 0", vld_cnt - vbase, ld_done_cnt - lbase); end
   endtask

`ifdef DMEM_UNALIGNED_EN
   task automatic test_unaligned;
      logic done, wr;
      logic [3:0] strb;
      logic [31:0] data, wdata, a;
      do_load(3'd6, 32'h0000_6001, 32'h1122_3344, 32'hAABB_CCDD, done, data);
      checks++; if (done !== 1'b1 || data !== 32'h3344_CCDD) begin
         errors++; $display("FAIL lwl_k1: got done=%b data=%h required 1 3344ccdd", done, data); end
      do_load(3'd7, 32'h0000_6001, 32'h1122_3344, 32'hAABB_CCDD, done, data);
      checks++; if (done !== 1'b1 || data !== 32'hAA11_2233) begin
         errors++; $display("FAIL lwr_k1: got done=%b data=%h required 1 aa112233", done, data); end
      do_store(3'd5, 32'h0000_6002, 32'h1234_5678, wr, strb, wdata, a);
      checks++; if (wr !== 1'b1 || strb !== 4'b1100 || wdata !== 32'h5678_0000) begin
         errors++; $display("FAIL swr_k2: got wr=%b strb=%b wdata=%h required 1 1100 56780000", wr, strb, wdata); end
      do_store(3'd4, 32'h0000_6001, 32'h1234_5678, wr, strb, wdata, a);
      checks++; if (wr !== 1'b1 || strb !== 4'b0011 || wdata !== 32'h0000_1234) begin
         errors++; $display("FAIL swl_k1: got wr=%b strb=%b wdata=%h required 1 0011 00001234", wr, strb, wdata); end
   endtask
`else
   task automatic test_unaligned;
      int vbase = vld_cnt;
      issue(3'd6, 3'd0, 32'h0000_6001, 32'd0, 32'hAABB_CCDD);
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lwl_off_stall: got %b required 1", mem_stall); end
      tick; idle_inputs;
      checks++; if ({ld_done, bus_if.dreq_valid, mem_stall} !== 3'b100 || ld_data !== 32'hAABB_CCDD) begin
         errors++; $display("FAIL lwl_off_done: got ctrl=%b data=%h required 100 aabbccdd",
                            {ld_done, bus_if.dreq_valid, mem_stall}, ld_data); end
      tick;
      issue(3'd0, 3'd5, 32'h0000_6002, 32'h1234_5678, 32'd0);
      tick; idle_inputs;
      checks++; if ({ld_done, bus_if.dreq_valid, mem_busy} !== 3'b001) begin
         errors++; $display("FAIL swr_off_done: got %b required 001", {ld_done, bus_if.dreq_valid, mem_busy}); end
      tick;
      checks++; if (mem_busy !== 1'b0 || vld_cnt != vbase) begin
         errors++; $display("FAIL unaligned_off_no_bus: got busy=%b valid cycles=%0d required 0 0", mem_busy, vld_cnt - vbase); end
   endtask
`endif

   initial begin
      test_reset;
      test_lb;
      test_sh;
      test_load_extract;
      test_store_lanes;
      test_back_to_back;
      test_flush;
      test_except;
      test_unaligned;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
